// File: rtl/max1452_pkg.sv
// Shared definitions for the MAX1452 serial link: receiver state encoding,
// default bit timing and the command bytes used by the transmit sequencer.
package max1452_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // 50 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic [7:0] CMD_BAUD_SYNC = 8'h01;
  localparam logic [7:0] CMD_READ_OP   = 8'h09;
  localparam logic [7:0] CMD_WRITE_OP  = 8'h19;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/max1452_rx_fifo.sv
// Show-ahead byte FIFO for received UART data. Head entry is visible on
// rd_data straight from storage; a full FIFO drops new bytes and flags overflow.
module max1452_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clr_err,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic do_pop;
  logic do_push;
  logic ovf_set;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A new overflow wins over a simultaneous clear.
      if (ovf_set) overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = ~empty;

endmodule

// File: rtl/max1452_uart_rx.sv
// UART 8N1 receiver for MAX1452 read-back bytes on DIO. Synchronizes the line,
// votes 3 mid-bit samples per bit and buffers good bytes in a show-ahead FIFO.
module max1452_uart_rx
  import max1452_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs_rx,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err,
  output logic       rx_busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_SAMP_A  = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_SAMP_B  = CW'(MID);
  localparam logic [CW-1:0] CNT_RESOLVE = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);

  logic sync1, sync2, sync3;
  logic rx_s;
  logic start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rs_rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rx_s       = sync2;
  assign start_edge = sync3 & ~sync2;

  rx_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        samp_a;
  logic        samp_b;
  logic        push;
  logic        fe_q;
  logic        maj;
  logic        resolve;
  logic [CW-1:0] cnt_next;

  // Third vote is the live synced sample at the resolve count.
  assign maj      = majority3(samp_a, samp_b, rx_s);
  assign resolve  = (cnt == CNT_RESOLVE);
  assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      push    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      push <= 1'b0;
      fe_q <= 1'b0;
      if (cnt == CNT_SAMP_A) samp_a <= rx_s;
      if (cnt == CNT_SAMP_B) samp_b <= rx_s;
      case (state)
        RX_IDLE: begin
          if (start_edge) begin
            cnt   <= '0;
            state <= RX_START;
          end
        end
        RX_START: begin
          cnt <= cnt_next;
          if (resolve) begin
            if (maj) begin
              state <= RX_IDLE;
            end else begin
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          cnt <= cnt_next;
          if (resolve) begin
            shreg <= {maj, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        RX_STOP: begin
          cnt <= cnt_next;
          if (resolve) begin
            if (maj) begin
              push  <= 1'b1;
              state <= RX_IDLE;
            end else begin
              fe_q  <= 1'b1;
              cnt   <= '0;
              state <= RX_WAIT_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: begin
          // A held-low line (break) keeps us here, so it reports only once.
          if (!rx_s) cnt <= '0;
          else if (cnt == CNT_LAST) state <= RX_IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign frame_err = fe_q;
  assign rx_busy   = (state != RX_IDLE);

  max1452_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(shreg),
    .pop      (rd_req),
    .clr_err  (clr_err),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .overflow (overflow)
  );

endmodule
